sqrt_stream_ctrl: RTL

SQRT_STREAM_CTRL -- requirements
Module: sqrt_stream_ctrl

---
 rtl/sqrt_stream_ctrl.sv | 113 +++++++++++
 1 files changed

// File: rtl/sqrt_stream_ctrl.sv
// Stream wrapper around a multi-cycle square-root core: accepts operands over a
// valid/ready handshake, sequences start/run/stop to the core and holds the result.
module sqrt_stream_ctrl #(
    parameter int NBITSIN    = 32,
    parameter int NITER      = NBITSIN / 2,
    parameter int CONTINUOUS = 1,
    parameter int NCOUNT     = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NBITSIN-1:0]   xin,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NBITSIN/2-1:0] sqrt_out,
    output logic                 busy,
    output logic                 start,
    output logic                 stop,
    output logic [NBITSIN-1:0]   x_core,
    input  logic [NBITSIN/2-1:0] sqrt_core,
    output logic [NCOUNT-1:0]    op_count
);
    localparam int HW = NBITSIN / 2;
    localparam int CW = (NITER > 1) ? $clog2(NITER) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_RUN, S_STOP, S_CAPTURE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NBITSIN-1:0]  x_core_q, x_core_d;
    logic [HW-1:0]       sqrt_out_q, sqrt_out_d;
    logic [NCOUNT-1:0]   op_count_q, op_count_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_core_d   = x_core_q;
        sqrt_out_d = sqrt_out_q;
        op_count_d = op_count_q;
        in_ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_core_d = xin;
                    state_d  = S_START;
                end
            end
            S_START: begin
                cnt_d   = CW'(NITER - 1);
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == '0) state_d = S_STOP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_STOP:    state_d = S_CAPTURE;
            S_CAPTURE: begin
                sqrt_out_d = sqrt_core;
                state_d    = S_DONE;
            end
            S_DONE: begin
                in_ready = (CONTINUOUS != 0) ? out_ready : 1'b0;
                if (out_ready) begin
                    op_count_d = op_count_q + NCOUNT'(1);
                    if ((CONTINUOUS != 0) && in_valid) begin
                        x_core_d = xin;
                        state_d  = S_START;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort overrides every update except the return to IDLE; ignored while idle.
        if (abort && state_q != S_IDLE) begin
            state_d    = S_IDLE;
            x_core_d   = x_core_q;
            sqrt_out_d = sqrt_out_q;
            op_count_d = op_count_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            x_core_q   <= '0;
            sqrt_out_q <= '0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_core_q   <= x_core_d;
            sqrt_out_q <= sqrt_out_d;
            op_count_q <= op_count_d;
        end
    end

    assign start     = (state_q == S_START);
    assign stop      = (state_q == S_STOP);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign x_core    = x_core_q;
    assign sqrt_out  = sqrt_out_q;
    assign op_count  = op_count_q;

endmodule
